// File: rtl/memshare_vnu_in_sched.sv
`default_nettype none
// ============================================================================
// Module   : memshare_vnu_in_sched
// Purpose  : Time-multiplexes VNU IB-LUT reads of one column share group onto
//            the IB-RAM ports of the owner columns. Shared columns are served
//            by their host owner in later phases. Responses are steered back
//            to the requesting column through a per-lane tag pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module memshare_vnu_in_sched #(
   parameter int                   GROUP_NUM        = 5,
   parameter logic [GROUP_NUM-1:0] SHARE_COL_CONFIG = 5'b10101,
   parameter int                   ADDR_W           = 6,
   parameter int                   DATA_W           = 4,
   parameter int                   RAM_LAT          = 2
) (
   input  logic                        sys_clk,
   input  logic                        rstn,
   input  logic [GROUP_NUM-1:0]        req_valid,
   input  logic [GROUP_NUM*ADDR_W-1:0] req_addr,
   output logic                        req_ready,
   output logic [GROUP_NUM-1:0]        ram_rd_en,
   output logic [GROUP_NUM*ADDR_W-1:0] ram_rd_addr,
   input  logic [GROUP_NUM*DATA_W-1:0] ram_rd_data,
   output logic [GROUP_NUM-1:0]        rsp_valid,
   output logic [GROUP_NUM*DATA_W-1:0] rsp_data,
   output logic                        busy
);

   // ---------------- elaboration-time share mapping ----------------
   function automatic bit f_shared(input int i);
      logic [GROUP_NUM-1:0] v;
      v = SHARE_COL_CONFIG >> i;
      return v[0];
   endfunction

   // nearest owner cyclically above column i
   function automatic int f_host(input int i);
      int h;
      h = -1;
      for (int d = GROUP_NUM - 1; d >= 1; d--) begin
         if (!f_shared((i + d) % GROUP_NUM)) h = (i + d) % GROUP_NUM;
      end
      return h;
   endfunction

   function automatic int f_dist(input int i);
      return (f_host(i) - i + GROUP_NUM) % GROUP_NUM;
   endfunction

   // order among the columns sharing the same host, nearest first
   function automatic int f_rank(input int i);
      int r;
      r = 0;
      for (int k = 0; k < GROUP_NUM; k++) begin
         if (k != i && f_shared(k) && f_host(k) == f_host(i) && f_dist(k) < f_dist(i)) r++;
      end
      return r;
   endfunction

   function automatic int f_nphase();
      int m;
      int n;
      m = 0;
      for (int j = 0; j < GROUP_NUM; j++) begin
         n = 0;
         for (int i = 0; i < GROUP_NUM; i++) begin
            if (f_shared(i) && f_host(i) == j) n++;
         end
         if (!f_shared(j) && n > m) m = n;
      end
      return 1 + m;
   endfunction

   // column whose request owner lane j carries in phase p (-1 = none)
   function automatic int f_sel(input int j, input int p);
      int s;
      s = -1;
      if (!f_shared(j)) begin
         if (p == 0) s = j;
         else begin
            for (int i = 0; i < GROUP_NUM; i++) begin
               if (f_shared(i) && f_host(i) == j && f_rank(i) == p - 1) s = i;
            end
         end
      end
      return s;
   endfunction

   localparam int             CW         = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;
   localparam int             NPHASE     = f_nphase();
   localparam int             PW         = (NPHASE > 1) ? $clog2(NPHASE) : 1;
   localparam logic [PW-1:0]  LAST_PHASE = PW'(NPHASE - 1);

   if (SHARE_COL_CONFIG == {GROUP_NUM{1'b1}}) begin : g_bad_cfg
      $error("memshare_vnu_in_sched: SHARE_COL_CONFIG has no owner column");
   end

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

   state_t                        state_q, state_d;
   logic [PW-1:0]                 phase_q, phase_d;
   logic                          req_ready_q, req_ready_d;
   logic                          busy_q, busy_d;
   logic                          accept;
   logic [GROUP_NUM-1:0]          batch_valid_q, batch_valid_d;
   logic [GROUP_NUM*ADDR_W-1:0]   batch_addr_q, batch_addr_d;
   logic [GROUP_NUM-1:0][CW-1:0]  lane_tgt;
   logic [GROUP_NUM-1:0][RAM_LAT-1:0]         tag_v_q, tag_v_d;
   logic [GROUP_NUM-1:0][RAM_LAT-1:0][CW-1:0] tag_c_q, tag_c_d;
   logic [GROUP_NUM-1:0]          rsp_valid_q, rsp_valid_d;
   logic [GROUP_NUM*DATA_W-1:0]   rsp_data_q, rsp_data_d;

   wire  [GROUP_NUM-1:0][NPHASE-1:0]              cand_en;
   wire  [GROUP_NUM-1:0][NPHASE-1:0][ADDR_W-1:0]  cand_addr;
   wire  [GROUP_NUM-1:0][NPHASE-1:0][CW-1:0]      cand_tgt;

   // static request routing: which batch entry each lane sees in each phase
   for (genvar j = 0; j < GROUP_NUM; j++) begin : g_lane
      for (genvar p = 0; p < NPHASE; p++) begin : g_phase
         localparam int SEL = f_sel(j, p);
         if (SEL >= 0) begin : g_map
            assign cand_en[j][p]   = batch_valid_q[SEL];
            assign cand_addr[j][p] = batch_addr_q[SEL*ADDR_W +: ADDR_W];
            assign cand_tgt[j][p]  = CW'(SEL);
         end else begin : g_none
            assign cand_en[j][p]   = 1'b0;
            assign cand_addr[j][p] = '0;
            assign cand_tgt[j][p]  = '0;
         end
      end
   end

   // phase sequencing, batch capture and next-cycle handshake/busy flags
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      accept        = req_ready_q & (|req_valid);
      batch_valid_d = batch_valid_q;
      batch_addr_d  = batch_addr_q;
      if (accept) begin
         state_d       = ST_ISSUE;
         phase_d       = '0;
         batch_valid_d = req_valid;
         batch_addr_d  = req_addr;
      end else if (state_q == ST_ISSUE) begin
         if (phase_q == LAST_PHASE) begin
            state_d = ST_IDLE;
            phase_d = '0;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
      req_ready_d = (state_d == ST_IDLE) || (phase_d == LAST_PHASE);
      busy_d      = (state_d != ST_IDLE) || (|tag_v_d) || (|rsp_valid_d);
   end

   // drive each owner port with the request selected for the current phase
   always_comb begin
      ram_rd_en   = '0;
      ram_rd_addr = '0;
      lane_tgt    = '0;
      if (state_q == ST_ISSUE) begin
         for (int j = 0; j < GROUP_NUM; j++) begin
            for (int p = 0; p < NPHASE; p++) begin
               if (phase_q == PW'(p)) begin
                  ram_rd_en[j]                    = cand_en[j][p];
                  ram_rd_addr[j*ADDR_W +: ADDR_W] = cand_en[j][p] ? cand_addr[j][p] : '0;
                  lane_tgt[j]                     = cand_tgt[j][p];
               end
            end
         end
      end
   end

   // tag pipeline follows each read through the RAM latency
   always_comb begin
      tag_v_d = '0;
      tag_c_d = '0;
      for (int j = 0; j < GROUP_NUM; j++) begin
         tag_v_d[j][0] = ram_rd_en[j];
         tag_c_d[j][0] = lane_tgt[j];
         for (int s = 1; s < RAM_LAT; s++) begin
            tag_v_d[j][s] = tag_v_q[j][s-1];
            tag_c_d[j][s] = tag_c_q[j][s-1];
         end
      end
   end

   // tail stage steers returning data to the column it was read for
   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      for (int j = 0; j < GROUP_NUM; j++) begin
         for (int c = 0; c < GROUP_NUM; c++) begin
            if (tag_v_q[j][RAM_LAT-1] && tag_c_q[j][RAM_LAT-1] == CW'(c)) begin
               rsp_valid_d[c]                 = 1'b1;
               rsp_data_d[c*DATA_W +: DATA_W] = ram_rd_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   // state registers; reset drops any batch and in-flight reads
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         req_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         batch_valid_q <= '0;
         batch_addr_q  <= '0;
         tag_v_q       <= '0;
         tag_c_q       <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         req_ready_q   <= req_ready_d;
         busy_q        <= busy_d;
         batch_valid_q <= batch_valid_d;
         batch_addr_q  <= batch_addr_d;
         tag_v_q       <= tag_v_d;
         tag_c_q       <= tag_c_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_memshare_vnu_in_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_memshare_vnu_in_sched
// Purpose  : Self-checking bench; one instance with the default share pattern
//            and one with no shared columns, each with a RAM model returning
//            the low address bits after two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memshare_vnu_in_sched;
   localparam int G   = 5;
   localparam int AW  = 6;
   localparam int DW  = 4;
   localparam int LAT = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {int cyc; int col; logic [DW-1:0] data;} exp_t;
   exp_t q_a[$];
   exp_t q_z[$];

   logic [G-1:0]    rv_a, rv_z, en_a, en_z, rspv_a, rspv_z;
   logic [G*AW-1:0] ra_a, ra_z, rda_a, rda_z;
   logic [G*DW-1:0] rdd_a, rdd_z, rspd_a, rspd_z;
   logic            rdy_a, rdy_z, busy_a, busy_z;
   logic [G*AW-1:0] pa1, pa2, pz1, pz2;

   memshare_vnu_in_sched #(.GROUP_NUM(G), .SHARE_COL_CONFIG(5'b10101), .ADDR_W(AW),
                           .DATA_W(DW), .RAM_LAT(LAT)) dut_a (
      .sys_clk(clk), .rstn(rstn), .req_valid(rv_a), .req_addr(ra_a), .req_ready(rdy_a),
      .ram_rd_en(en_a), .ram_rd_addr(rda_a), .ram_rd_data(rdd_a),
      .rsp_valid(rspv_a), .rsp_data(rspd_a), .busy(busy_a));

   memshare_vnu_in_sched #(.GROUP_NUM(G), .SHARE_COL_CONFIG(5'b00000), .ADDR_W(AW),
                           .DATA_W(DW), .RAM_LAT(LAT)) dut_z (
      .sys_clk(clk), .rstn(rstn), .req_valid(rv_z), .req_addr(ra_z), .req_ready(rdy_z),
      .ram_rd_en(en_z), .ram_rd_addr(rda_z), .ram_rd_data(rdd_z),
      .rsp_valid(rspv_z), .rsp_data(rspd_z), .busy(busy_z));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // two-cycle RAM returning address[3:0]
   always @(posedge clk) begin
      pa1 <= rda_a; pa2 <= pa1;
      pz1 <= rda_z; pz2 <= pz1;
   end
   always_comb begin
      rdd_a = '0;
      rdd_z = '0;
      for (int i = 0; i < G; i++) begin
         rdd_a[i*DW +: DW] = pa2[i*AW +: DW];
         rdd_z[i*DW +: DW] = pz2[i*AW +: DW];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [G*AW-1:0] mk(input int base);
      logic [G*AW-1:0] r;
      for (int i = 0; i < G; i++) r[i*AW +: AW] = AW'(base + i);
      return r;
   endfunction

   // default pattern: cols 1,3 phase 0; cols 0,2 phase 1; col 4 phase 2
   task automatic push_a(input int t, input logic [G-1:0] v, input logic [G*AW-1:0] a);
      int ph[G];
      ph = '{1, 0, 1, 0, 2};
      for (int c = 0; c < G; c++)
         if (v[c]) q_a.push_back('{t + 2 + ph[c] + LAT, c, a[c*AW +: DW]});
   endtask

   task automatic push_z(input int t, input logic [G-1:0] v, input logic [G*AW-1:0] a);
      for (int c = 0; c < G; c++)
         if (v[c]) q_z.push_back('{t + 2 + LAT, c, a[c*AW +: DW]});
   endtask

   // response scoreboard: every column, every cycle
   always @(negedge clk) begin
      for (int c = 0; c < G; c++) begin
         int ia;
         int iz;
         ia = -1;
         iz = -1;
         foreach (q_a[k]) if (q_a[k].cyc == cyc && q_a[k].col == c) ia = k;
         foreach (q_z[k]) if (q_z[k].cyc == cyc && q_z[k].col == c) iz = k;
         chk($sformatf("a_rsp_valid[%0d]@%0d", c, cyc), 64'(rspv_a[c]), 64'(ia >= 0));
         if (ia >= 0) begin
            chk($sformatf("a_rsp_data[%0d]@%0d", c, cyc), 64'(rspd_a[c*DW +: DW]), 64'(q_a[ia].data));
            q_a.delete(ia);
         end
         chk($sformatf("z_rsp_valid[%0d]@%0d", c, cyc), 64'(rspv_z[c]), 64'(iz >= 0));
         if (iz >= 0) begin
            chk($sformatf("z_rsp_data[%0d]@%0d", c, cyc), 64'(rspd_z[c*DW +: DW]), 64'(q_z[iz].data));
            q_z.delete(iz);
         end
      end
   end

   initial begin
      int t;
      logic [G-1:0]    v;
      logic [G*AW-1:0] a;
      rv_a = '0; ra_a = '0; rv_z = '0; ra_z = '0;
      rstn = 1'b0;
      step(3);
      chk("rst_ready", 64'(rdy_a), 64'd1);
      chk("rst_en", 64'(en_a), 64'd0);
      chk("rst_addr", 64'(rda_a), 64'd0);
      chk("rst_rsp_valid", 64'(rspv_a), 64'd0);
      chk("rst_rsp_data", 64'(rspd_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_ready_z", 64'(rdy_z), 64'd1);
      rstn = 1'b1;
      step(1);
      chk("post_rst_ready", 64'(rdy_a), 64'd1);
      chk("post_rst_busy", 64'(busy_a), 64'd0);

      // all columns valid, addr 8+i
      t = cyc;
      rv_a = '1; ra_a = mk(8); push_a(t, '1, mk(8));
      step(1); rv_a = '0;
      chk("A_en_t1", 64'(en_a), 64'b01010);
      chk("A_l1_t1", 64'(rda_a[AW +: AW]), 64'd9);
      chk("A_l3_t1", 64'(rda_a[3*AW +: AW]), 64'd11);
      chk("A_busy_t1", 64'(busy_a), 64'd1);
      step(1);
      chk("A_l1_t2", 64'(rda_a[AW +: AW]), 64'd8);
      chk("A_l3_t2", 64'(rda_a[3*AW +: AW]), 64'd10);
      step(1);
      chk("A_en_t3", 64'(en_a), 64'b00010);
      chk("A_l1_t3", 64'(rda_a[AW +: AW]), 64'd12);
      chk("A_l3_t3", 64'(rda_a[3*AW +: AW]), 64'd0);
      chk("A_ready_t3", 64'(rdy_a), 64'd1);
      step(5);
      chk("A_busy_end", 64'(busy_a), 64'd0);

      // only column 4 valid, addr 0x25
      t = cyc;
      a = '0; a[4*AW +: AW] = 6'h25;
      rv_a = 5'b10000; ra_a = a; push_a(t, 5'b10000, a);
      step(1); rv_a = '0;
      chk("B_en_t1", 64'(en_a), 64'd0);
      step(1);
      chk("B_en_t2", 64'(en_a), 64'd0);
      step(1);
      chk("B_en_t3", 64'(en_a), 64'b00010);
      chk("B_addr_t3", 64'(rda_a), 64'(30'h25 << AW));
      step(1);
      chk("B_en_t4", 64'(en_a), 64'd0);
      step(2);
      chk("B_busy_t6", 64'(busy_a), 64'd1);
      step(1);
      chk("B_busy_t7", 64'(busy_a), 64'd0);
      step(1);

      // back-to-back batches
      t = cyc;
      rv_a = '1; ra_a = mk(16); push_a(t, '1, mk(16));
      step(1); rv_a = '0;
      step(2);
      chk("C_ready_t3", 64'(rdy_a), 64'd1);
      chk("C_en_t3", 64'(en_a), 64'b00010);
      rv_a = '1; ra_a = mk(40); push_a(cyc, '1, mk(40));
      step(1); rv_a = '0;
      chk("C_en_t4", 64'(en_a), 64'b01010);
      chk("C_l1_t4", 64'(rda_a[AW +: AW]), 64'd41);
      chk("C_l3_t4", 64'(rda_a[3*AW +: AW]), 64'd43);
      step(8);

      // reset in the middle of a batch
      rv_a = '1; ra_a = mk(48);
      step(1); rv_a = '0;
      step(1);
      rstn = 1'b0;
      #1;
      chk("D_busy_in_rst", 64'(busy_a), 64'd0);
      chk("D_en_in_rst", 64'(en_a), 64'd0);
      step(1);
      rstn = 1'b1;
      chk("D_ready_after_rst", 64'(rdy_a), 64'd1);
      rv_a = 5'b00011; ra_a = mk(8'h33); push_a(cyc, 5'b00011, mk(8'h33));
      step(1); rv_a = '0;
      chk("D_en_t1", 64'(en_a), 64'b00010);
      step(8);

      // no shared columns: a new batch every cycle
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("E_ready_%0d", k), 64'(rdy_z), 64'd1);
         v = G'($urandom_range(1, 31));
         a = G*AW'({$urandom(), $urandom()});
         rv_z = v; ra_z = a; push_z(cyc, v, a);
         step(1);
         chk($sformatf("E_en_%0d", k), 64'(en_z), 64'(v));
      end
      rv_z = '0;
      step(1);
      chk("E_ready_end", 64'(rdy_z), 64'd1);
      step(6);

      chk("sb_a_drained", 64'(q_a.size()), 64'd0);
      chk("sb_z_drained", 64'(q_z.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire

// File: doc/memshare_vnu_in_sched.md
# memshare_vnu_in_sched

Time-multiplexing scheduler for the IB-RAM input side of one column share group in the layered LDPC decoder. It accepts one batch of VNU IB-LUT read requests, one per column. Shared columns own no IB-RAM port, so their reads are issued through the port of a host owner column in later phases. Returned data is routed back to the requesting column. It generalises the partial IB-RAM input wrapper to any group size and share pattern, and adds phase sequencing, a response tag pipeline and a batch handshake.

## Interface
- GROUP_NUM, 5, number of columns in the share group
- SHARE_COL_CONFIG, 5'b10101, [GROUP_NUM-1:0]; bit i = 1 means column i is shared (no own port), 0 means owner
- ADDR_W, 6, IB-LUT read address width per column
- DATA_W, 4, IB-LUT read data width per column
- RAM_LAT, 2, IB-RAM read latency in cycles, from rd_en to data (≥1)
- sys_clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  GROUP_NUM  per-column request present in the offered batch
- req_addr  in  GROUP_NUM*ADDR_W  per-column address; column i at [i*ADDR_W +: ADDR_W]
- req_ready  out  1  batch accept strobe; a batch is taken on a cycle with req_ready=1 and |req_valid=1
- ram_rd_en  out  GROUP_NUM  read enable per IB-RAM port; shared-column lanes are tied 0
- ram_rd_addr  out  GROUP_NUM*ADDR_W  read address per port; shared lanes are tied 0
- ram_rd_data  in  GROUP_NUM*DATA_W  read data per port, valid RAM_LAT cycles after ram_rd_en
- rsp_valid  out  GROUP_NUM  one-cycle response pulse per requesting column
- rsp_data  out  GROUP_NUM*DATA_W  response data per column; holds its last value when not valid
- busy  out  1  high when FSM is not IDLE or any tag-pipeline stage is valid

## Operation
- Elaboration-time mapping:
  - host(i) of shared column i = nearest owner j at cyclic distance 1..GROUP_NUM-1 above i.
  - rank(i) = position among the columns sharing the same host, ordered by ascending cyclic distance (rank 0 = nearest).
  - NPHASE = 1 + max number of columns hosted by one owner.
  - Elaboration fails if SHARE_COL_CONFIG is all ones.
- Default config 10101 gives owners 1 and 3; col0→1 (rank 0), col4→1 (rank 1), col2→3 (rank 0); NPHASE=3.
- FSM states:
  - IDLE: req_ready=1. Goes to ISSUE on accept.
  - ISSUE: phase counter p runs 0..NPHASE-1.
    - In the last phase, req_ready=1. An accept in that cycle restarts at p=0; otherwise the FSM goes to IDLE.
- Batch register: on accept, latches req_valid and req_addr for all columns. Requests with valid=0 are dropped.
- Port drive per owner lane j in phase p:
  - p=0: own request.
  - p=k≥1: the hosted column with rank k-1.
  - ram_rd_en[j] is asserted only if the selected request is valid. If ram_rd_en[j]=0, ram_rd_addr[j] is 0.
- Phases are never skipped. Batch latency and issue cadence are fixed, independent of the valid pattern.
- Tag pipeline, RAM_LAT stages per owner lane: carries a valid bit and the target column index.
  - Tail stage selects ram_rd_data[j] into a registered rsp_data[target], and pulses rsp_valid[target].
- At most one lane targets a given column per cycle, by construction.

## Timing
- Accept on cycle t; phase p is issued in cycle t+1+p.
- ram_rd_data is sampled in cycle t+1+p+RAM_LAT.
- rsp_valid is high in cycle t+2+p+RAM_LAT. Owner-column latency is RAM_LAT+2.
- Throughput: one batch per NPHASE cycles. With back-to-back accepts in the last phase, there are no idle cycles on the ports.
- Reset values: FSM in IDLE, p=0, batch and tag registers cleared.
  - Outputs: req_ready=1, ram_rd_en=0, ram_rd_addr=0, rsp_valid=0, rsp_data=0, busy=0.
  - No accept occurs while rstn=0.
- Reset mid-batch: in-flight reads are discarded and no rsp_valid is produced afterwards. A new batch is accepted in the first cycle after rstn rises.
- req_valid=0 with req_ready=1: no accept, state unchanged.
- SHARE_COL_CONFIG all zeros: NPHASE=1, req_ready=1 every cycle, and the block is a pure RAM_LAT+2 pipeline.

## Test plan
- Reset: hold rstn=0 → check all outputs at their reset values. Release rstn → req_ready=1 and busy=0.
- Default config, all columns valid, req_addr[i]=8+i, RAM model returns addr[3:0], accept at t:
  - ram_rd_addr lane1 = 9/8/12 at t+1/t+2/t+3.
  - lane3 = 11/10 at t+1/t+2; ram_rd_en[3]=0 at t+3.
  - rsp_valid: cols 1,3 at t+4 (data 9, 11); cols 0,2 at t+5 (8, 10); col4 at t+6 (12).
- Only col4 valid (addr 0x25):
  - only ram_rd_en[1] is asserted, at t+3, with address 0x25.
  - only rsp_valid[4] pulses, at t+6, with data 0x5.
  - busy falls at t+7.
- Back-to-back: second batch offered during t+3 and accepted → its phase 0 is issued at t+4, with no gap on the ports.
- Reset mid-batch: rstn=0 at t+2 for one cycle → no rsp_valid ever asserted for that batch. A fresh batch afterwards responds normally.
- SHARE_COL_CONFIG=5'b00000, a new batch every cycle → req_ready stays 1, and each column responds at t+4 with its own data.
